mmap_cmd_parser: RTL and testbench

//  Consumes the byte stream from the upstream UART buffer (mp_rx_data / mp_new_rx_data)
//  and decodes framed packets into single-byte writes on the map/texture RAM port.

---
 rtl/mmap_proto_pkg.sv | 18 +
 rtl/byte_gap_timer.sv | 34 +++
 rtl/mmap_cmd_parser.sv | 182 ++++++++++++++++++
 tb/tb_mmap_cmd_parser.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmap_proto_pkg.sv
// Protocol constants shared by the map/texture command parser: framing byte,
// opcodes, error codes and parser state encoding.
package mmap_proto_pkg;

   localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;
   localparam logic [7:0] OP_WRITE       = 8'h01;
   localparam logic [7:0] OP_FILL        = 8'h02;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_OPCODE   = 2'd1;
   localparam logic [1:0] ERR_CHECKSUM = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   typedef enum logic [3:0] {
      S_SYNC, S_CMD, S_AH, S_AL, S_LEN, S_DATA, S_FILLB, S_FILL, S_CHK
   } state_t;

endpackage

// File: rtl/byte_gap_timer.sv
// Inter-byte gap watchdog: reloads on load_i, holds while freeze_i, and flags
// expire_o during the last idle cycle of the allowed gap.
module byte_gap_timer #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic freeze_i,
   output logic expire_o
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] RELOAD = W'(TIMEOUT_CYCLES);

   logic [W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = RELOAD;
      else if (!freeze_i && cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   // A load in the same cycle always beats expiry.
   assign expire_o = !load_i && !freeze_i && (cnt_q == W'(1));

endmodule

// File: rtl/mmap_cmd_parser.sv
// Decodes framed WRITE/FILL packets from the UART byte buffer into single-byte
// map/texture RAM writes, with back-pressure during FILL bursts.
module mmap_cmd_parser
   import mmap_proto_pkg::*;
#(
   parameter int         ADDRBITS       = 13,
   parameter int         TIMEOUT_CYCLES = 1_000_000,
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DFLT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          mp_rx_data,
   input  logic                mp_new_rx_data,
   output logic                mp_busy,
   output logic                mem_we,
   output logic [ADDRBITS-1:0] mem_addr,
   output logic [7:0]          mem_wdata,
   output logic                pkt_done,
   output logic                pkt_err,
   output logic [1:0]          err_code
);

   state_t              state_q, state_d;
   logic [ADDRBITS-1:0] addr_q, addr_d;
   logic [8:0]          cnt_q, cnt_d;
   logic [7:0]          chk_q, chk_d;
   logic                fill_q, fill_d;
   logic                we_q, we_d;
   logic [ADDRBITS-1:0] waddr_q, waddr_d;
   logic [7:0]          wdata_q, wdata_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [1:0]          ecode_q, ecode_d;
   logic                tmr_expire;

   byte_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
      .clk      (clk),
      .rst      (rst),
      .load_i   (mp_new_rx_data || (state_q == S_SYNC)),
      .freeze_i (state_q == S_FILL),
      .expire_o (tmr_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_SYNC;
         addr_q  <= '0;
         cnt_q   <= '0;
         chk_q   <= '0;
         fill_q  <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ecode_q <= ERR_NONE;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         chk_q   <= chk_d;
         fill_q  <= fill_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ecode_q <= ecode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      chk_d   = chk_q;
      fill_d  = fill_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      ecode_d = ecode_q;

      if (mp_new_rx_data && busy_q) begin
         // Upstream ignored back-pressure: the byte is lost, abandon the packet.
         busy_d  = 1'b0;
         err_d   = 1'b1;
         ecode_d = ERR_CHECKSUM;
         state_d = S_SYNC;
      end else if (tmr_expire && state_q != S_SYNC) begin
         err_d   = 1'b1;
         ecode_d = ERR_TIMEOUT;
         state_d = S_SYNC;
      end else begin
         unique case (state_q)
            S_SYNC: if (mp_new_rx_data && mp_rx_data == SYNC_BYTE) begin
               chk_d   = '0;
               state_d = S_CMD;
            end
            S_CMD: if (mp_new_rx_data) begin
               chk_d = mp_rx_data;
               if (mp_rx_data == OP_WRITE || mp_rx_data == OP_FILL) begin
                  fill_d  = (mp_rx_data == OP_FILL);
                  state_d = S_AH;
               end else begin
                  err_d   = 1'b1;
                  ecode_d = ERR_OPCODE;
                  state_d = S_SYNC;
               end
            end
            S_AH: if (mp_new_rx_data) begin
               chk_d   = chk_q ^ mp_rx_data;
               addr_d  = ADDRBITS'({mp_rx_data, 8'h00});
               state_d = S_AL;
            end
            S_AL: if (mp_new_rx_data) begin
               chk_d   = chk_q ^ mp_rx_data;
               addr_d  = {addr_q[ADDRBITS-1:8], mp_rx_data};
               state_d = S_LEN;
            end
            S_LEN: if (mp_new_rx_data) begin
               chk_d   = chk_q ^ mp_rx_data;
               cnt_d   = (mp_rx_data == 8'h00) ? 9'd256 : {1'b0, mp_rx_data};
               state_d = fill_q ? S_FILLB : S_DATA;
            end
            S_DATA: if (mp_new_rx_data) begin
               chk_d   = chk_q ^ mp_rx_data;
               we_d    = 1'b1;
               waddr_d = addr_q;
               wdata_d = mp_rx_data;
               addr_d  = addr_q + ADDRBITS'(1);
               cnt_d   = cnt_q - 9'd1;
               if (cnt_q == 9'd1) state_d = S_CHK;
            end
            S_FILLB: if (mp_new_rx_data) begin
               chk_d   = chk_q ^ mp_rx_data;
               busy_d  = 1'b1;
               we_d    = 1'b1;
               waddr_d = addr_q;
               wdata_d = mp_rx_data;
               addr_d  = addr_q + ADDRBITS'(1);
               cnt_d   = cnt_q - 9'd1;
               state_d = S_FILL;
            end
            // wdata_q still holds the fill byte for the rest of the burst.
            S_FILL: if (cnt_q != 9'd0) begin
               we_d    = 1'b1;
               waddr_d = addr_q;
               addr_d  = addr_q + ADDRBITS'(1);
               cnt_d   = cnt_q - 9'd1;
            end else begin
               busy_d  = 1'b0;
               state_d = S_CHK;
            end
            S_CHK: if (mp_new_rx_data) begin
               if (mp_rx_data == chk_q) begin
                  done_d = 1'b1;
               end else begin
                  err_d   = 1'b1;
                  ecode_d = ERR_CHECKSUM;
               end
               state_d = S_SYNC;
            end
            default: state_d = S_SYNC;
         endcase
      end
   end

   assign mp_busy   = busy_q;
   assign mem_we    = we_q;
   assign mem_addr  = waddr_q;
   assign mem_wdata = wdata_q;
   assign pkt_done  = done_q;
   assign pkt_err   = err_q;
   assign err_code  = ecode_q;

endmodule

// File: tb/tb_mmap_cmd_parser.sv
// Bench for mmap_cmd_parser: vector table, timing corner sequences and a
// random packet stream checked against a byte-level packet interpreter.
module tb_mmap_cmd_parser;

   localparam int AMOD = 1 << 13;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_new = 1'b0;
   logic        mp_busy, mem_we, pkt_done, pkt_err;
   logic [12:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [1:0]  err_code;

   mmap_cmd_parser #(.ADDRBITS(13), .TIMEOUT_CYCLES(16), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .mp_rx_data(rx_data), .mp_new_rx_data(rx_new),
      .mp_busy(mp_busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_pass = 0;
   int last_cyc = 0;

   // Observed activity
   int mw_a[$], mw_d[$], mw_c[$], mev[$], mev_c[$];
   int busy_n = 0;

   always @(negedge clk) begin
      if (mem_we) begin
         mw_a.push_back(int'(mem_addr));
         mw_d.push_back(int'(mem_wdata));
         mw_c.push_back(cyc);
      end
      if (pkt_done) begin mev.push_back(0); mev_c.push_back(cyc); end
      if (pkt_err) begin mev.push_back(int'(err_code)); mev_c.push_back(cyc); end
      if (mp_busy) busy_n++;
   end

   // Expected activity from the reference interpreter
   logic [7:0] sq[$];
   int ew_a[$], ew_d[$], ev[$];

   typedef struct {
      int          n;
      logic [95:0] b;
      int          nw;
      int          a0, d0, al, dl;
      int          code;
   } vec_t;
   vec_t tv[7];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      mw_a.delete(); mw_d.delete(); mw_c.delete(); mev.delete(); mev_c.delete();
      busy_n = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int w;
      w = 0;
      repeat (gap) tick();
      while (mp_busy && w < 600) begin tick(); w++; end
      if (w >= 600) chk("busy_wait_timeout", 1, 0);
      rx_data = b;
      rx_new = 1'b1;
      last_cyc = cyc;
      tick();
      rx_new = 1'b0;
   endtask

   task automatic send_case1();
      send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
      send_byte(8'h02, 0); send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h20, 0);
   endtask

   // Walks the byte stream frame by frame and lists the writes and packet outcomes
   // a correct parser must produce; a stream ending mid-frame ends in a timeout.
   task automatic model_run();
      int i, n, addr, cnt;
      logic [7:0] cmd, ah, al, ln, b, x;
      bit trunc;
      i = 0;
      n = sq.size();
      while (i < n) begin
         if (sq[i] != 8'hA5) begin i++; continue; end
         i++;
         if (i >= n) begin ev.push_back(3); break; end
         cmd = sq[i]; i++;
         if (cmd != 8'h01 && cmd != 8'h02) begin ev.push_back(1); continue; end
         if (i + 3 > n) begin ev.push_back(3); break; end
         ah = sq[i]; al = sq[i+1]; ln = sq[i+2]; i += 3;
         addr = int'({ah, al}) % AMOD;
         cnt = (ln == 8'h00) ? 256 : int'(ln);
         x = cmd ^ ah ^ al ^ ln;
         trunc = 1'b0;
         if (cmd == 8'h01) begin
            for (int k = 0; k < cnt; k++) begin
               if (i >= n) begin trunc = 1'b1; break; end
               b = sq[i]; i++; x ^= b;
               ew_a.push_back(addr); ew_d.push_back(int'(b));
               addr = (addr + 1) % AMOD;
            end
         end else if (i >= n) begin
            trunc = 1'b1;
         end else begin
            b = sq[i]; i++; x ^= b;
            for (int k = 0; k < cnt; k++) begin
               ew_a.push_back(addr); ew_d.push_back(int'(b));
               addr = (addr + 1) % AMOD;
            end
         end
         if (trunc || i >= n) begin ev.push_back(3); break; end
         ev.push_back((sq[i] == x) ? 0 : 2);
         i++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int fill_cyc, w, nb;
      logic [7:0] cmd, ah, al, ln, x, b;

      tv[0] = '{8, {8'hA5,8'h01,8'h00,8'h10,8'h02,8'h11,8'h22,8'h20,32'h0}, 2, 'h10, 'h11, 'h11, 'h22, 0};
      tv[1] = '{8, {8'hA5,8'h01,8'h00,8'h10,8'h02,8'h11,8'h22,8'h21,32'h0}, 2, 'h10, 'h11, 'h11, 'h22, 2};
      tv[2] = '{3, {8'h00,8'hA5,8'h07,72'h0}, 0, 0, 0, 0, 0, 1};
      tv[3] = '{8, {8'hA5,8'h01,8'h00,8'h10,8'h02,8'h11,8'h22,8'h20,32'h0}, 2, 'h10, 'h11, 'h11, 'h22, 0};
      tv[4] = '{7, {8'hA5,8'h02,8'h01,8'h00,8'h01,8'h55,8'h57,40'h0}, 1, 'h100, 'h55, 'h100, 'h55, 0};
      tv[5] = '{7, {8'hA5,8'h01,8'hFF,8'hFF,8'h01,8'h3C,8'h3C,40'h0}, 1, 'h1FFF, 'h3C, 'h1FFF, 'h3C, 0};
      tv[6] = '{9, {8'h11,8'h22,8'hA5,8'h01,8'h00,8'h00,8'h01,8'h99,8'h99,24'h0}, 1, 0, 'h99, 0, 'h99, 0};

      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_mem_we", int'(mem_we), 0);
      chk("reset_busy", int'(mp_busy), 0);
      chk("reset_done", int'(pkt_done), 0);
      chk("reset_err", int'(pkt_err), 0);
      chk("reset_err_code", int'(err_code), 0);
      chk("reset_addr", int'(mem_addr), 0);
      chk("reset_wdata", int'(mem_wdata), 0);

      // Vector table
      for (int r = 0; r < 7; r++) begin
         clear_obs();
         for (int k = 0; k < tv[r].n; k++) send_byte(tv[r].b[95-8*k -: 8], 0);
         repeat (6) tick();
         chk($sformatf("vec%0d_nwrites", r), mw_a.size(), tv[r].nw);
         chk($sformatf("vec%0d_nevents", r), mev.size(), 1);
         if (mev.size() > 0) chk($sformatf("vec%0d_outcome", r), mev[0], tv[r].code);
         if (tv[r].nw > 0 && mw_a.size() == tv[r].nw) begin
            chk($sformatf("vec%0d_addr0", r), mw_a[0], tv[r].a0);
            chk($sformatf("vec%0d_data0", r), mw_d[0], tv[r].d0);
            chk($sformatf("vec%0d_addrN", r), mw_a[tv[r].nw-1], tv[r].al);
            chk($sformatf("vec%0d_dataN", r), mw_d[tv[r].nw-1], tv[r].dl);
         end
      end
      chk("err_code_held", int'(err_code), 1);

      // FILL across the address wrap: timing of writes and back-pressure
      clear_obs();
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h1F, 0);
      send_byte(8'hFE, 0); send_byte(8'h04, 0); send_byte(8'h7F, 0);
      fill_cyc = last_cyc;
      send_byte(8'h98, 0);
      repeat (4) tick();
      chk("fillwrap_nwrites", mw_a.size(), 4);
      chk("fillwrap_busy_cycles", busy_n, 4);
      chk("fillwrap_busy_end", int'(mp_busy), 0);
      chk("fillwrap_nevents", mev.size(), 1);
      if (mev.size() > 0) chk("fillwrap_outcome", mev[0], 0);
      if (mw_a.size() == 4) begin
         chk("fillwrap_first_cycle", mw_c[0], fill_cyc + 1);
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("fillwrap_addr%0d", k), mw_a[k], (16'h1FFE + k) % AMOD);
            chk($sformatf("fillwrap_data%0d", k), mw_d[k], 'h7F);
            chk($sformatf("fillwrap_cycle%0d", k), mw_c[k], fill_cyc + 1 + k);
         end
      end

      // Inter-byte timeout
      clear_obs();
      send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
      repeat (20) tick();
      chk("timeout_nevents", mev.size(), 1);
      if (mev.size() > 0) begin
         chk("timeout_code", mev[0], 3);
         chk("timeout_cycle", mev_c[0], last_cyc + 17);
      end
      clear_obs();
      send_case1();
      repeat (4) tick();
      chk("after_timeout_nwrites", mw_a.size(), 2);
      chk("after_timeout_nevents", mev.size(), 1);
      if (mev.size() > 0) chk("after_timeout_outcome", mev[0], 0);

      // A byte landing on the expiry cycle keeps the packet alive
      clear_obs();
      send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
      send_byte(8'h02, 15); send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h20, 0);
      repeat (4) tick();
      chk("edge_timeout_nevents", mev.size(), 1);
      if (mev.size() > 0) chk("edge_timeout_outcome", mev[0], 0);
      chk("edge_timeout_nwrites", mw_a.size(), 2);

      // Reset in the middle of a 256-byte FILL
      clear_obs();
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
      send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'hAB, 0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_burst_we", int'(mem_we), 0);
      chk("rst_burst_busy", int'(mp_busy), 0);
      repeat (20) tick();
      chk("rst_burst_nwrites", mw_a.size(), 2);
      chk("rst_burst_nevents", mev.size(), 0);
      clear_obs();
      send_case1();
      repeat (4) tick();
      chk("after_rst_nwrites", mw_a.size(), 2);
      chk("after_rst_nevents", mev.size(), 1);
      if (mev.size() > 0) chk("after_rst_outcome", mev[0], 0);

      // Random packet stream
      clear_obs();
      sq.delete(); ew_a.delete(); ew_d.delete(); ev.delete();
      for (int p = 0; p < 30; p++) begin
         if ($urandom_range(0, 3) == 0) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            sq.push_back(b);
         end
         if ($urandom_range(0, 9) == 0) begin
            sq.push_back(8'hA5);
            sq.push_back(8'($urandom_range(3, 255)));
            continue;
         end
         cmd = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
         ah = 8'($urandom_range(0, 255));
         al = 8'($urandom_range(0, 255));
         ln = (cmd == 8'h02) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(1, 10));
         sq.push_back(8'hA5); sq.push_back(cmd); sq.push_back(ah); sq.push_back(al); sq.push_back(ln);
         x = cmd ^ ah ^ al ^ ln;
         nb = (cmd == 8'h02) ? 1 : int'(ln);
         for (int k = 0; k < nb; k++) begin
            b = 8'($urandom_range(0, 255));
            sq.push_back(b);
            x ^= b;
         end
         sq.push_back(($urandom_range(0, 6) == 0) ? (x ^ 8'h5A) : x);
      end
      foreach (sq[k]) send_byte(sq[k], $urandom_range(0, 3));
      w = 0;
      while (mp_busy && w < 400) begin tick(); w++; end
      repeat (40) tick();
      model_run();
      chk("rnd_nwrites", mw_a.size(), ew_a.size());
      for (int k = 0; k < mw_a.size() && k < ew_a.size(); k++) begin
         chk($sformatf("rnd_addr%0d", k), mw_a[k], ew_a[k]);
         chk($sformatf("rnd_data%0d", k), mw_d[k], ew_d[k]);
      end
      chk("rnd_nevents", mev.size(), ev.size());
      for (int k = 0; k < mev.size() && k < ev.size(); k++)
         chk($sformatf("rnd_event%0d", k), mev[k], ev[k]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
